demux_dispatch_queue: RTL and testbench
=======================================

Name: demux_dispatch_queue

Overview:
- Buffered sequencer upstream of the 8-bit 1-to-3 demultiplexer. It accepts (byte, destination) pairs over a valid/ready handshake, queues them, and presents one entry at a time on the demux data and select inputs.
- While an entry is presented, a strobe is held until the addressed destination acknowledges. This lets producers burst writes to the three demux outputs without stalling on slow consumers.

Parameters:
- WIDTH, 8, data byte width; matches the demux I/Q width.
- DEPTH, 4, queue entries (power of two, >= 2); excludes the output stage.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_DATA  in  WIDTH  byte to dispatch.
- IN_DEST  in  2  destination code: 01=Q1, 10=Q2, 11=Q3, 00=no destination.
- IN_VALID  in  1  producer offers IN_DATA/IN_DEST.
- IN_READY  out  1  queue can accept; equals !full (combinational).
- I  out  WIDTH  to demux data input.
- S  out  2  to demux select input.
- STB  out  1  the presented entry on I/S is valid.
- DEST_READY  in  3  per-destination acknowledge; bit0=Q1, bit1=Q2, bit2=Q3.
- COUNT  out  clog2(DEPTH)+1  queue occupancy, excluding the output stage.
- DROP  out  1  one-cycle pulse: an entry with IN_DEST=00 was accepted and discarded.

Behaviour:
- Reset (async, RST=1): I=0, S=00, STB=0, COUNT=0, DROP=0, pointers cleared, state IDLE. IN_READY=1 once queue empty. In-flight and queued entries are lost; no acknowledge is honoured during reset.
- Accept: handshake completes at an edge where IN_VALID=1 and IN_READY=1.
  - IN_DEST != 00: entry written at the tail, COUNT+1.
  - IN_DEST = 00: entry not stored; DROP=1 for the following cycle only.
- Full: COUNT=DEPTH makes IN_READY=0, even if a pop occurs in the same cycle. No bypass or fall-through.
- Pointers wrap modulo DEPTH. A push and a pop in the same cycle leave COUNT unchanged.
- State IDLE (STB=0, S=00, I=0): if COUNT>0, pop the head into the output register. Next cycle I=data, S=dest, STB=1, state SEND.
- State SEND:
  - I, S and STB hold stable until the acknowledge edge.
  - Acknowledge = STB=1 and DEST_READY[S-1]=1 at a rising edge. Other DEST_READY bits are ignored.
  - On acknowledge with COUNT>0: the next head loads at the same edge (back-to-back). STB stays 1; state stays SEND.
  - On acknowledge with COUNT=0: I=0, S=00, STB=0, state IDLE.
  - No timeout; SEND waits indefinitely.
- Latency: an entry accepted at edge k into an empty queue with IDLE output is on I/S with STB=1 after edge k+1. Sustained throughput is 1 entry/cycle when the destination holds DEST_READY high.
- Ordering: strict FIFO across all destinations. A stalled destination blocks entries for the others (head-of-line blocking is intended).
- S is 00 whenever STB=0, so the demux outputs no destination while idle.

Test Plan:
- Reset then idle: assert RST mid-cycle with 2 entries queued and STB=1 -> I=00000000, S=00, STB=0, COUNT=0, IN_READY=1 immediately, without waiting for an edge.
- Single dispatch: push IN_DATA=5, IN_DEST=01 with DEST_READY=001 -> after 1 edge I=00000101, S=01, STB=1; at the next edge STB=0, S=00.
- Back-to-back: push 5->01, 15->10, 7->11 on consecutive cycles with DEST_READY=111 -> S sequence 01,10,11 on three consecutive cycles, STB continuously 1, then STB=0.
- Stall and full: DEST_READY=000, push 6 entries to dest 10 -> first entry held on I/S and 4 queued; COUNT=4, IN_READY=0; 6th entry not accepted until DEST_READY[1]=1; then order is preserved.
- Wrong acknowledge: present dest 11 with DEST_READY=011 for 3 cycles -> I/S/STB unchanged; DEST_READY=100 -> advances at that edge.
- Drop: push IN_DEST=00 with IN_DATA=9 -> handshake completes, DROP=1 for exactly one cycle, COUNT unchanged, nothing presented.

Source files
------------

// File: rtl/demux_dispatch_queue.sv
// Buffered dispatcher feeding an 8-bit 1-to-3 demultiplexer.
// Producers push (byte, destination) pairs through a valid/ready handshake.
// Entries are queued in a FIFO and presented one at a time on I/S with STB.
// Each entry is held until the addressed destination acknowledges it.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   IN_DATA/IN_DEST   byte and destination code (01=Q1, 10=Q2, 11=Q3, 00=discard)
//   IN_VALID/IN_READY producer handshake; IN_READY is !full
//   I, S, STB         presented entry to the demux; S is 00 whenever STB is 0
//   DEST_READY        per-destination acknowledge (bit0=Q1, bit1=Q2, bit2=Q3)
//   COUNT             queue occupancy, excluding the output stage
//   DROP              one-cycle pulse after an IN_DEST=00 entry is accepted
module demux_dispatch_queue #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [WIDTH-1:0]         IN_DATA,
   input  logic [1:0]               IN_DEST,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   output logic [WIDTH-1:0]         I,
   output logic [1:0]               S,
   output logic                     STB,
   input  logic [2:0]               DEST_READY,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     DROP
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  mem_data [DEPTH];
   logic [1:0]        mem_dest [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_d;
   logic              accept, push, pop, sel_ready, ack;

   // Full blocks new input even if a pop happens in the same cycle.
   assign IN_READY = (COUNT != CW'(DEPTH));
   assign accept   = IN_VALID && IN_READY;
   assign push     = accept && (IN_DEST != 2'b00);

   always_comb begin
      sel_ready = 1'b0;
      unique case (S)
         2'b01:   sel_ready = DEST_READY[0];
         2'b10:   sel_ready = DEST_READY[1];
         2'b11:   sel_ready = DEST_READY[2];
         default: sel_ready = 1'b0;
      endcase
   end

   assign ack = STB && sel_ready;
   // The output stage takes a new head when empty or when its entry retires.
   assign pop = (COUNT != '0) && (!STB || ack);

   always_comb begin
      count_d = COUNT;
      unique case ({push, pop})
         2'b10:   count_d = COUNT + CW'(1);
         2'b01:   count_d = COUNT - CW'(1);
         default: count_d = COUNT;
      endcase
   end

   // Storage is not reset; occupancy and pointers define what is valid.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_data[wr_ptr_q] <= IN_DATA;
         mem_dest[wr_ptr_q] <= IN_DEST;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         COUNT    <= '0;
         DROP     <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         COUNT <= count_d;
         DROP  <= accept && (IN_DEST == 2'b00);
      end
   end

   // Output stage FSM with registered I/S/STB.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         I       <= '0;
         S       <= 2'b00;
         STB     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  I       <= mem_data[rd_ptr_q];
                  S       <= mem_dest[rd_ptr_q];
                  STB     <= 1'b1;
                  state_q <= StSend;
               end
            end
            StSend: begin
               if (pop) begin
                  I <= mem_data[rd_ptr_q];
                  S <= mem_dest[rd_ptr_q];
               end else if (ack) begin
                  I       <= '0;
                  S       <= 2'b00;
                  STB     <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_demux_dispatch_queue.sv
module tb_demux_dispatch_queue;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] IN_DATA;
   logic [1:0] IN_DEST;
   logic       IN_VALID;
   logic       IN_READY;
   logic [7:0] I;
   logic [1:0] S;
   logic       STB;
   logic [2:0] DEST_READY;
   logic [2:0] COUNT;
   logic       DROP;

   int checks = 0;
   int failures = 0;

   demux_dispatch_queue #(.WIDTH(8), .DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_DEST(IN_DEST),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .I(I), .S(S), .STB(STB),
      .DEST_READY(DEST_READY), .COUNT(COUNT), .DROP(DROP)
   );

   always #5 CLK = ~CLK;

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // {I,S,STB} packed for compact comparisons.
   function automatic logic [10:0] out_vec();
      return {I, S, STB};
   endfunction

   task automatic test_reset();
      RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; IN_DEST = '0; DEST_READY = '0;
      step(); step();
      RST = 1'b0;
      step();
      checks++;
      if ({out_vec(), COUNT, DROP, IN_READY} !== {8'h00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state got I=%h S=%b STB=%b COUNT=%0d DROP=%b RDY=%b want 00/00/0/0/0/1",
                  I, S, STB, COUNT, DROP, IN_READY);
      end
   endtask

   task automatic test_single();
      DEST_READY = 3'b001;
      IN_VALID = 1'b1; IN_DATA = 8'd5; IN_DEST = 2'b01;
      step();
      IN_VALID = 1'b0;
      checks++;
      if ({STB, COUNT} !== {1'b0, 3'd1}) begin
         failures++;
         $display("FAIL single_queued got STB=%b COUNT=%0d want 0/1", STB, COUNT);
      end
      step();
      checks++;
      if ({out_vec(), COUNT} !== {8'd5, 2'b01, 1'b1, 3'd0}) begin
         failures++;
         $display("FAIL single_present got I=%h S=%b STB=%b COUNT=%0d want 05/01/1/0",
                  I, S, STB, COUNT);
      end
      step();
      checks++;
      if (out_vec() !== {8'd0, 2'b00, 1'b0}) begin
         failures++;
         $display("FAIL single_retire got I=%h S=%b STB=%b want 00/00/0", I, S, STB);
      end
      DEST_READY = 3'b000;
   endtask

   task automatic test_back_to_back();
      logic [7:0]  dat [3];
      logic [1:0]  dst [3];
      dat[0] = 8'd5; dat[1] = 8'd15; dat[2] = 8'd7;
      dst[0] = 2'b01; dst[1] = 2'b10; dst[2] = 2'b11;
      DEST_READY = 3'b111;
      IN_VALID = 1'b1; IN_DATA = dat[0]; IN_DEST = dst[0];
      step();
      for (int k = 0; k < 3; k++) begin
         if (k < 2) begin
            IN_DATA = dat[k+1]; IN_DEST = dst[k+1];
         end else begin
            IN_VALID = 1'b0;
         end
         step();
         checks++;
         if (out_vec() !== {dat[k], dst[k], 1'b1}) begin
            failures++;
            $display("FAIL b2b_entry%0d got I=%h S=%b STB=%b want %h/%b/1",
                     k, I, S, STB, dat[k], dst[k]);
         end
      end
      step();
      checks++;
      if ({out_vec(), COUNT} !== {8'd0, 2'b00, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL b2b_end got I=%h S=%b STB=%b COUNT=%0d want 00/00/0/0", I, S, STB, COUNT);
      end
      DEST_READY = 3'b000;
   endtask

   task automatic test_stall_full();
      DEST_READY = 3'b000;
      IN_DEST = 2'b10;
      IN_VALID = 1'b1;
      for (int k = 0; k < 5; k++) begin
         IN_DATA = 8'h10 + 8'(k);
         step();
      end
      IN_DATA = 8'h15;
      checks++;
      if ({out_vec(), COUNT, IN_READY} !== {8'h10, 2'b10, 1'b1, 3'd4, 1'b0}) begin
         failures++;
         $display("FAIL full_state got I=%h S=%b STB=%b COUNT=%0d RDY=%b want 10/10/1/4/0",
                  I, S, STB, COUNT, IN_READY);
      end
      step(); step();
      checks++;
      if ({I, COUNT, IN_READY} !== {8'h10, 3'd4, 1'b0}) begin
         failures++;
         $display("FAIL full_hold got I=%h COUNT=%0d RDY=%b want 10/4/0", I, COUNT, IN_READY);
      end
      DEST_READY = 3'b010;
      step();
      checks++;
      if ({I, COUNT, IN_READY} !== {8'h11, 3'd3, 1'b1}) begin
         failures++;
         $display("FAIL full_release got I=%h COUNT=%0d RDY=%b want 11/3/1", I, COUNT, IN_READY);
      end
      step();
      IN_VALID = 1'b0;
      checks++;
      if ({I, COUNT} !== {8'h12, 3'd3}) begin
         failures++;
         $display("FAIL full_sixth got I=%h COUNT=%0d want 12/3", I, COUNT);
      end
      for (int k = 3; k < 6; k++) begin
         step();
         checks++;
         if (out_vec() !== {8'h10 + 8'(k), 2'b10, 1'b1}) begin
            failures++;
            $display("FAIL full_order%0d got I=%h S=%b STB=%b want %h/10/1",
                     k, I, S, STB, 8'h10 + 8'(k));
         end
      end
      step();
      checks++;
      if ({STB, COUNT} !== {1'b0, 3'd0}) begin
         failures++;
         $display("FAIL full_drain got STB=%b COUNT=%0d want 0/0", STB, COUNT);
      end
      DEST_READY = 3'b000;
   endtask

   task automatic test_wrong_ack();
      DEST_READY = 3'b011;
      IN_VALID = 1'b1; IN_DATA = 8'h33; IN_DEST = 2'b11;
      step();
      IN_VALID = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_vec() !== {8'h33, 2'b11, 1'b1}) begin
            failures++;
            $display("FAIL wrong_ack_hold%0d got I=%h S=%b STB=%b want 33/11/1", k, I, S, STB);
         end
         step();
      end
      checks++;
      if (out_vec() !== {8'h33, 2'b11, 1'b1}) begin
         failures++;
         $display("FAIL wrong_ack_final got I=%h S=%b STB=%b want 33/11/1", I, S, STB);
      end
      DEST_READY = 3'b100;
      step();
      checks++;
      if (out_vec() !== {8'h00, 2'b00, 1'b0}) begin
         failures++;
         $display("FAIL right_ack got I=%h S=%b STB=%b want 00/00/0", I, S, STB);
      end
      DEST_READY = 3'b000;
   endtask

   task automatic test_drop();
      IN_VALID = 1'b1; IN_DATA = 8'd9; IN_DEST = 2'b00;
      checks++;
      if (IN_READY !== 1'b1) begin
         failures++;
         $display("FAIL drop_ready got RDY=%b want 1", IN_READY);
      end
      step();
      IN_VALID = 1'b0;
      checks++;
      if ({DROP, COUNT, STB, S} !== {1'b1, 3'd0, 1'b0, 2'b00}) begin
         failures++;
         $display("FAIL drop_pulse got DROP=%b COUNT=%0d STB=%b S=%b want 1/0/0/00",
                  DROP, COUNT, STB, S);
      end
      step();
      checks++;
      if ({DROP, COUNT, STB} !== {1'b0, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL drop_once got DROP=%b COUNT=%0d STB=%b want 0/0/0", DROP, COUNT, STB);
      end
   endtask

   task automatic test_reset_midcycle();
      DEST_READY = 3'b000;
      IN_VALID = 1'b1; IN_DEST = 2'b01;
      for (int k = 0; k < 3; k++) begin
         IN_DATA = 8'h41 + 8'(k);
         step();
      end
      IN_VALID = 1'b0;
      checks++;
      if ({out_vec(), COUNT} !== {8'h41, 2'b01, 1'b1, 3'd2}) begin
         failures++;
         $display("FAIL pre_reset got I=%h S=%b STB=%b COUNT=%0d want 41/01/1/2", I, S, STB, COUNT);
      end
      #2;
      RST = 1'b1;
      DEST_READY = 3'b111;
      #1;
      checks++;
      if ({out_vec(), COUNT, IN_READY} !== {8'h00, 2'b00, 1'b0, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL async_reset got I=%h S=%b STB=%b COUNT=%0d RDY=%b want 00/00/0/0/1",
                  I, S, STB, COUNT, IN_READY);
      end
      step();
      RST = 1'b0;
      step();
      checks++;
      if ({STB, COUNT} !== {1'b0, 3'd0}) begin
         failures++;
         $display("FAIL post_reset_idle got STB=%b COUNT=%0d want 0/0", STB, COUNT);
      end
      DEST_READY = 3'b000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall_full();
      test_wrong_ack();
      test_drop();
      test_reset_midcycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
